// File: rtl/clockdiv_pkg.sv
// clockdiv_pkg -- shared definitions for the clock-divider controller.
//   state_t            controller FSM encoding (also exposed as dbg_state)
//   MIN_DIV            smallest divisor the divider can produce
//   PKG_DEFAULT_DIV    divisor driven after reset
//   PKG_SETTLE_CYCLES  cycles held after a divisor change before ack
package clockdiv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        APPLY     = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    localparam logic [15:0] MIN_DIV           = 16'd2;
    localparam int          PKG_DEFAULT_DIV   = 2;
    localparam int          PKG_SETTLE_CYCLES = 4;

endpackage

// File: rtl/clockdiv.sv
// clockdiv -- simple programmable clock divider driven by clockdiv_ctrl.
// clkout is high for divideby cycles, then low for divideby cycles.
//   clk       in   system clock
//   reset     in   synchronous active-high reset (clkout low, counter clear)
//   divideby  in   half-period in clk cycles (>= 2)
//   clkout    out  divided clock
module clockdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divideby,
    output logic        clkout
);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 16'd0;
            clkout <= 1'b0;
        end else if (cnt >= divideby - 16'd1) begin
            cnt    <= 16'd0;
            clkout <= ~clkout;
        end else begin
            cnt    <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/clockdiv_rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
//   clk, reset  in   clock, synchronous active-high reset (pointer -> requester 0)
//   req         in   request vector
//   advance     in   a grant is being taken this cycle; pointer moves past winner
//   grant       out  one-hot grant (zero when no request)
//   idx         out  index of the winner (pointer value when idle)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       idx
);

    // ptr names the requester that wins a tie
    logic ptr;

    always_comb begin
        idx   = ptr;
        grant = 2'b00;
        case (req)
            2'b01:   idx = 1'b0;
            2'b10:   idx = 1'b1;
            default: idx = ptr;
        endcase
        if (|req) begin
            grant[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~idx;
        end
    end

endmodule

// File: rtl/clockdiv_ctrl.sv
// clockdiv_ctrl -- arbitrates divisor-change requests and reprograms a
// clockdiv instance glitch-safely (change applied just after a falling edge
// of clkout, or after a timeout if clkout is stuck).
//   clk, reset  in   clock, synchronous active-high reset
//   req[1:0]    in   per-requester change request
//   div0, div1  in   requested divisors, sampled at grant
//   clkout      in   divided clock looped back from clockdiv
//   divideby    out  divisor driven to clockdiv
//   div_reset   out  reset driven to clockdiv
//   ack, nack   out  one-cycle completion / rejection pulses
//   busy        out  high whenever the FSM is not IDLE
//   owner       out  current or last granted requester
//   dbg_state   out  FSM state for observation
//
// Handshake: a requester raises req[i] with div<i> stable and holds both
// until it sees ack[i] or nack[i] for one cycle; it must then drop req[i]
// for at least one cycle. Once granted the request runs to completion even
// if req[i] falls. No new grant is made in the cycle an ack/nack is shown,
// so a req still high then is not mistaken for a fresh request.
module clockdiv_ctrl
    import clockdiv_pkg::*;
#(
    parameter int DEFAULT_DIV   = PKG_DEFAULT_DIV,
    parameter int SETTLE_CYCLES = PKG_SETTLE_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] div0,
    input  logic [15:0] div1,
    input  logic        clkout,
    output logic [15:0] divideby,
    output logic        div_reset,
    output logic [1:0]  ack,
    output logic [1:0]  nack,
    output logic        busy,
    output logic        owner,
    output state_t      dbg_state
);

    state_t      state, state_n;
    logic [15:0] divideby_n, lat_div, lat_div_n, sel_div;
    logic [16:0] cnt, cnt_n;
    logic [1:0]  ack_n, nack_n, arb_req, arb_grant;
    logic        div_reset_n, busy_n, owner_n, clkout_q, arb_idx, arb_adv;

    assign arb_req   = (state == IDLE && ack == 2'b00 && nack == 2'b00) ? req : 2'b00;
    assign arb_adv   = |arb_req;
    assign sel_div   = arb_grant[1] ? div1 : div0;
    assign dbg_state = state;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (arb_adv),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    always_comb begin
        state_n     = state;
        divideby_n  = divideby;
        lat_div_n   = lat_div;
        cnt_n       = cnt;
        div_reset_n = 1'b0;
        ack_n       = 2'b00;
        nack_n      = 2'b00;
        owner_n     = owner;
        case (state)
            IDLE: begin
                if (arb_adv) begin
                    owner_n   = arb_idx;
                    lat_div_n = sel_div;
                    if (sel_div < MIN_DIV) begin
                        nack_n[arb_idx] = 1'b1;
                    end else if (sel_div == divideby) begin
                        ack_n[arb_idx] = 1'b1;
                    end else begin
                        state_n = WAIT_EDGE;
                        cnt_n   = 17'd0;
                    end
                end
            end
            WAIT_EDGE: begin
                // cnt counts completed WAIT_EDGE cycles; leaving when it
                // reads 2*divideby+1 gives 2*divideby+2 cycles in total.
                if ((clkout_q && !clkout) || cnt == {divideby, 1'b1}) begin
                    state_n     = APPLY;
                    divideby_n  = lat_div;
                    div_reset_n = 1'b1;
                end else begin
                    cnt_n = cnt + 17'd1;
                end
            end
            APPLY: begin
                state_n = SETTLE;
                cnt_n   = 17'd0;
            end
            SETTLE: begin
                if (cnt == 17'(SETTLE_CYCLES - 1)) begin
                    state_n      = IDLE;
                    ack_n[owner] = 1'b1;
                end else begin
                    cnt_n = cnt + 17'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            divideby  <= 16'(DEFAULT_DIV);
            lat_div   <= 16'd0;
            cnt       <= 17'd0;
            div_reset <= 1'b1;
            ack       <= 2'b00;
            nack      <= 2'b00;
            busy      <= 1'b0;
            owner     <= 1'b0;
            clkout_q  <= 1'b0;
        end else begin
            state     <= state_n;
            divideby  <= divideby_n;
            lat_div   <= lat_div_n;
            cnt       <= cnt_n;
            div_reset <= div_reset_n;
            ack       <= ack_n;
            nack      <= nack_n;
            busy      <= busy_n;
            owner     <= owner_n;
            clkout_q  <= clkout;
        end
    end

endmodule

// File: tb/tb_clockdiv_ctrl.sv
module tb_clockdiv_ctrl;
    import clockdiv_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] div0 = 16'd0;
    logic [15:0] div1 = 16'd0;
    logic        force_low = 1'b0;
    logic        div_clk;
    logic        clkout_fb;
    logic [15:0] divideby;
    logic        div_reset;
    logic [1:0]  ack, nack;
    logic        busy, owner;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;
    int multi_hot = 0;

    always #5 clk = ~clk;

    assign clkout_fb = force_low ? 1'b0 : div_clk;

    clockdiv_ctrl #(.DEFAULT_DIV(2), .SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .div0      (div0),
        .div1      (div1),
        .clkout    (clkout_fb),
        .divideby  (divideby),
        .div_reset (div_reset),
        .ack       (ack),
        .nack      (nack),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    clockdiv u_div (
        .clk      (clk),
        .reset    (div_reset),
        .divideby (divideby),
        .clkout   (div_clk)
    );

    always @(negedge clk) begin
        if (!reset && $countones(ack | nack) > 1) multi_hot++;
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req   = 2'b00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // Raise one request, follow it until ack/nack, then keep req low one cycle.
    // Times are in cycles after req was raised (1 = cycle after the grant).
    task automatic do_req(input int who, input logic [15:0] d,
                          output int t_ack, output int t_nack, output int t_apply,
                          output int n_rst, output int n_busy, output int n_wait,
                          output int n_early, output logic fell, output logic [1:0] resp);
        logic        fb_h [0:255];
        logic [15:0] start_div;
        t_ack = -1; t_nack = -1; t_apply = -1;
        n_rst = 0; n_busy = 0; n_wait = 0; n_early = 0;
        fell = 1'b0; resp = 2'b00;
        start_div = divideby;
        if (who == 0) div0 = d; else div1 = d;
        req[who] = 1'b1;
        fb_h[0] = clkout_fb;
        for (int t = 1; t < 200; t++) begin
            tick();
            fb_h[t] = clkout_fb;
            if (div_reset) begin
                n_rst++;
                t_apply = t;
                if (t >= 2) fell = (fb_h[t-1] == 1'b0) && (fb_h[t-2] == 1'b1);
            end else if (t_apply < 0 && divideby != start_div) begin
                n_early++;
            end
            if (busy) n_busy++;
            if (dbg_state == WAIT_EDGE) n_wait++;
            if (ack != 2'b00 || nack != 2'b00) begin
                resp = ack | nack;
                if (ack != 2'b00) t_ack = t; else t_nack = t;
                break;
            end
        end
        check("resp_seen", (resp != 2'b00), 1);
        req[who] = 1'b0;
        tick();
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];

    initial begin
        int t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, acks;
        logic fell;
        logic [1:0] resp;
        logic [15:0] e;

        // reset values while reset is held
        repeat (3) tick();
        check("rst_divideby", divideby, 2);
        check("rst_div_reset", div_reset, 1);
        check("rst_ack", ack, 0);
        check("rst_nack", nack, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;
        tick();
        check("div_reset_release", div_reset, 0);

        // single change 2 -> 6, applied on a falling edge
        do_req(0, 16'd6, t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, fell, resp);
        check("t1_resp", resp, 2'b01);
        check("t1_rst_pulses", n_rst, 1);
        check("t1_fell_before_apply", fell, 1);
        check("t1_no_early_change", n_early, 0);
        check("t1_wait_in_range", (n_wait >= 1 && n_wait <= 6), 1);
        check("t1_ack_after_apply", t_ack - t_apply, 5);
        check("t1_divideby", divideby, 6);

        // simultaneous requests: requester 0 first, then 1
        reset_dut();
        exp_q = {16'd4, 16'd8};
        div0 = 16'd4; div1 = 16'd8;
        req = 2'b11;
        for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
            tick();
            if (ack != 2'b00) begin
                e = exp_q.pop_front();
                if (e == 16'd4) begin
                    check("t2_first_ack", ack, 2'b01);
                    check("t2_first_owner", owner, 0);
                    check("t2_first_div", divideby, 4);
                    req[0] = 1'b0;
                end else begin
                    check("t2_second_ack", ack, 2'b10);
                    check("t2_second_owner", owner, 1);
                    check("t2_second_div", divideby, 8);
                    req[1] = 1'b0;
                end
            end
        end
        check("t2_all_done", exp_q.size(), 0);
        req = 2'b00;
        tick();

        // divisor below minimum is rejected
        reset_dut();
        do_req(1, 16'd1, t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, fell, resp);
        check("t3_resp", resp, 2'b10);
        check("t3_nack_time", t_nack, 1);
        check("t3_no_div_reset", n_rst, 0);
        check("t3_no_busy", n_busy, 0);
        check("t3_divideby", divideby, 2);

        // same divisor: immediate ack, no reprogramming
        do_req(0, 16'd2, t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, fell, resp);
        check("t4_resp", resp, 2'b01);
        check("t4_ack_time", t_ack, 1);
        check("t4_no_busy", n_busy, 0);
        check("t4_no_div_reset", n_rst, 0);

        // stuck-low clkout with divideby=3 -> timeout after 8 cycles
        do_req(0, 16'd3, t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, fell, resp);
        check("t5_setup_div", divideby, 3);
        force_low = 1'b1;
        repeat (2) tick();
        do_req(0, 16'd5, t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, fell, resp);
        check("t5_wait_cycles", n_wait, 8);
        check("t5_apply_time", t_apply, 9);
        check("t5_no_edge", fell, 0);
        check("t5_ack_time", t_ack, 14);
        check("t5_divideby", divideby, 5);
        force_low = 1'b0;

        // reset during SETTLE aborts, then the same request completes
        div0 = 16'd10;
        req = 2'b01;
        for (int t = 0; t < 100 && dbg_state != SETTLE; t++) tick();
        check("t6_reached_settle", dbg_state, SETTLE);
        reset = 1'b1;
        req = 2'b00;
        tick();
        reset = 1'b0;
        acks = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (ack != 2'b00 || nack != 2'b00) acks++;
        end
        check("t6_no_ack_after_abort", acks, 0);
        check("t6_divideby_default", divideby, 2);
        check("t6_idle", dbg_state, IDLE);
        do_req(0, 16'd10, t_ack, t_nack, t_apply, n_rst, n_busy, n_wait, n_early, fell, resp);
        check("t6_resp", resp, 2'b01);
        check("t6_rst_pulses", n_rst, 1);
        check("t6_ack_after_apply", t_ack - t_apply, 5);
        check("t6_divideby", divideby, 10);

        check("ack_nack_onehot", multi_hot, 0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
